// File: rtl/rx_dword_packer.sv
// Packs I2C read bytes into 32-bit dwords for the HCI RX queue, with flush and byte count.
// Define RX_PACKER_BIG_ENDIAN_EN to place the first byte in [31:24] (default: little-endian).
module rx_dword_packer #(
   parameter int DataWidth    = 32,
   parameter int ByteCntWidth = 16,
   parameter int OutBufDepth  = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    byte_valid_i,
   input  logic [7:0]              byte_i,
   input  logic                    clear_i,
   input  logic                    flush_i,
   output logic                    rx_queue_wvalid_o,
   input  logic                    rx_queue_wready_i,
   output logic [DataWidth-1:0]    rx_queue_wdata_o,
   output logic [ByteCntWidth-1:0] byte_count_o,
   output logic                    flush_done_o,
   output logic                    overflow_o,
   output logic                    idle_o
);

   localparam int PtrW = (OutBufDepth > 1) ? $clog2(OutBufDepth) : 1;
   localparam int CntW = $clog2(OutBufDepth + 1);
   localparam logic [CntW-1:0] BufFull = CntW'(OutBufDepth);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_FLUSH   = 2'd2
   } state_e;

   // Unused lanes stay zero because the accumulator is zeroed on every push.
   function automatic logic [DataWidth-1:0] lane_insert(input logic [DataWidth-1:0] word,
                                                        input logic [1:0]           lane,
                                                        input logic [7:0]           data);
      logic [DataWidth-1:0] res;
      res = word;
`ifdef RX_PACKER_BIG_ENDIAN_EN
      res[5'd24 - {lane, 3'b000} +: 8] = data;
`else
      res[{lane, 3'b000} +: 8] = data;
`endif
      return res;
   endfunction

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      if (p == PtrW'(OutBufDepth - 1)) begin
         return '0;
      end else begin
         return p + PtrW'(1);
      end
   endfunction

   state_e                   state_r, state_s;
   logic [DataWidth-1:0]     acc_r, acc_s, acc_ins_s;
   logic [1:0]               idx_r, idx_s;
   logic                     full_r, full_s;
   logic [DataWidth-1:0]     mem_r [OutBufDepth];
   logic [PtrW-1:0]          wr_ptr_r, rd_ptr_r;
   logic [CntW-1:0]          cnt_r;
   logic [ByteCntWidth-1:0]  byte_count_r;
   logic                     overflow_r;
   logic                     flushing_s, accept_s, drop_s, pop_s, space_s, empty_s;
   logic                     push_s, flush_done_s;
   logic [DataWidth-1:0]     push_data_s;

   assign flushing_s = (state_r == ST_FLUSH);
   assign accept_s   = byte_valid_i && !full_r && !flushing_s;
   assign drop_s     = byte_valid_i && !accept_s;
   assign pop_s      = (cnt_r != '0) && rx_queue_wready_i;
   assign space_s    = (cnt_r != BufFull) || pop_s;
   assign empty_s    = (idx_r == 2'd0) && !full_r && (cnt_r == '0);
   assign acc_ins_s  = lane_insert(acc_r, idx_r, byte_i);

   // Accumulator update and buffer push selection (held dword, completed dword, flush partial).
   always_comb begin
      push_s      = 1'b0;
      push_data_s = acc_r;
      acc_s       = acc_r;
      idx_s       = idx_r;
      full_s      = full_r;
      if (full_r) begin
         if (space_s) begin
            push_s = 1'b1;
            acc_s  = '0;
            full_s = 1'b0;
         end else begin
            full_s = 1'b1;
         end
      end else if (accept_s) begin
         idx_s = idx_r + 2'd1;
         if (idx_r == 2'd3) begin
            if (space_s) begin
               push_s      = 1'b1;
               push_data_s = acc_ins_s;
               acc_s       = '0;
            end else begin
               acc_s  = acc_ins_s;
               full_s = 1'b1;
            end
         end else begin
            acc_s = acc_ins_s;
         end
      end else if (flushing_s && (idx_r != 2'd0) && space_s) begin
         push_s = 1'b1;
         acc_s  = '0;
         idx_s  = 2'd0;
      end else begin
         push_s = 1'b0;
      end
   end

   // Next-state logic; a byte arriving with flush_i is accepted before entering FLUSH.
   always_comb begin
      state_s      = state_r;
      flush_done_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (flush_i) begin
               state_s = ST_FLUSH;
            end else if (accept_s) begin
               state_s = ST_COLLECT;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_COLLECT: begin
            if (flush_i) begin
               state_s = ST_FLUSH;
            end else begin
               state_s = ST_COLLECT;
            end
         end
         ST_FLUSH: begin
            if (empty_s) begin
               state_s      = ST_IDLE;
               flush_done_s = !clear_i;
            end else begin
               state_s = ST_FLUSH;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= ST_IDLE;
      end else if (clear_i) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Accumulator registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_r  <= '0;
         idx_r  <= 2'd0;
         full_r <= 1'b0;
      end else if (clear_i) begin
         acc_r  <= '0;
         idx_r  <= 2'd0;
         full_r <= 1'b0;
      end else begin
         acc_r  <= acc_s;
         idx_r  <= idx_s;
         full_r <= full_s;
      end
   end

   // Output buffer storage; contents are only observed while the occupancy count is nonzero.
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= push_data_s;
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

   // Output buffer pointers and occupancy.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         cnt_r    <= '0;
      end else if (clear_i) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         cnt_r    <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= ptr_inc(wr_ptr_r);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   cnt_r <= cnt_r + CntW'(1);
            2'b01:   cnt_r <= cnt_r - CntW'(1);
            default: cnt_r <= cnt_r;
         endcase
      end
   end

   // Saturating accepted-byte counter and sticky overflow.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         byte_count_r <= '0;
         overflow_r   <= 1'b0;
      end else if (clear_i) begin
         byte_count_r <= '0;
         overflow_r   <= 1'b0;
      end else begin
         if (accept_s && (byte_count_r != {ByteCntWidth{1'b1}})) begin
            byte_count_r <= byte_count_r + ByteCntWidth'(1);
         end else begin
            byte_count_r <= byte_count_r;
         end
         overflow_r <= overflow_r | drop_s;
      end
   end

   assign rx_queue_wvalid_o = (cnt_r != '0);
   assign rx_queue_wdata_o  = (cnt_r != '0) ? mem_r[rd_ptr_r] : '0;
   assign byte_count_o      = byte_count_r;
   assign overflow_o        = overflow_r;
   assign flush_done_o      = flush_done_s;
   assign idle_o            = empty_s && !flushing_s;

endmodule
